// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the sum-to-15 turn controller.
package game_pkg;

  typedef enum logic [2:0] {
    INIT,
    C_WAIT,
    C_CHECK,
    H_WAIT,
    H_CHECK,
    DONE
  } state_t;

  typedef logic [3:0] move_t;

  localparam int unsigned MAX_MOVES  = 8;
  localparam int unsigned SLOTS      = 4;
  localparam int unsigned TARGET_SUM = 15;

  // One-hot taken bit for a move; all-zero when the move is outside 1..9.
  function automatic logic [8:0] move_onehot(move_t m);
    logic [8:0] b;
    b = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (m == move_t'(i + 1)) b[i] = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Request/valid handshake between the turn controller and the strategy engine.
interface game_sequencer_if;
  logic            cReq;
  game_pkg::move_t cMove;
  logic            cValid;

  modport master (input cReq, output cMove, output cValid);
  modport slave  (output cReq, input cMove, input cValid);
endinterface

// File: rtl/game_sequencer_sum15_check.sv
// Flags a win when any three filled slots of one player's list sum to 15.
module sum15_check
  import game_pkg::*;
(
  input  move_t      m0_i,
  input  move_t      m1_i,
  input  move_t      m2_i,
  input  move_t      m3_i,
  input  logic [2:0] fill_i,
  output logic       win_o
);

  function automatic logic is15(move_t a, move_t b, move_t c);
    logic [5:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c};
    return s == 6'(TARGET_SUM);
  endfunction

  // Slot 3 only takes part once four moves exist; zero-valued slots never count as filled.
  always_comb begin
    win_o = 1'b0;
    if (fill_i >= 3'd3 && is15(m0_i, m1_i, m2_i)) win_o = 1'b1;
    if (fill_i >= 3'd4 && (is15(m0_i, m1_i, m3_i) ||
                           is15(m0_i, m2_i, m3_i) ||
                           is15(m1_i, m2_i, m3_i))) win_o = 1'b1;
  end

endmodule

// File: rtl/game_sequencer.sv
// Turn controller for the sum-to-15 game: alternates engine and human moves,
// records them and detects win/draw. GAME_SEQ_HUMAN_FIRST_EN lets the human start.
module game_sequencer
  import game_pkg::*;
(
  input  logic             clock,
  input  logic             reset_L,
  input  logic             newGame_L,
  input  logic             enter_L,
  input  move_t            hMove,
  game_sequencer_if.slave  eng,
  output move_t            h3,
  output move_t            h2,
  output move_t            h1,
  output move_t            h0,
  output move_t            c3,
  output move_t            c2,
  output move_t            c1,
  output move_t            c0,
  output logic [8:0]       taken,
  output logic             cWin,
  output logic             hWin,
  output logic             draw,
  output logic             illegal
);

  state_t     state_q, state_d;
  move_t      c_slot_q [SLOTS];
  move_t      c_slot_d [SLOTS];
  move_t      h_slot_q [SLOTS];
  move_t      h_slot_d [SLOTS];
  logic [2:0] c_cnt_q, c_cnt_d;
  logic [2:0] h_cnt_q, h_cnt_d;
  logic [8:0] taken_q, taken_d;
  logic       cwin_q, cwin_d;
  logic       hwin_q, hwin_d;
  logic       draw_q, draw_d;
  logic       illegal_q, illegal_d;
  logic       enter_prev_q;

  logic       press;
  logic [8:0] c_bit, h_bit;
  logic       c_legal, h_legal;
  logic       c_win, h_win, all_played;

  assign press      = enter_prev_q & ~enter_L;
  assign c_bit      = move_onehot(eng.cMove);
  assign h_bit      = move_onehot(hMove);
  assign c_legal    = (|c_bit) && ((c_bit & taken_q) == '0);
  assign h_legal    = (|h_bit) && ((h_bit & taken_q) == '0);
  assign all_played = ({1'b0, c_cnt_q} + {1'b0, h_cnt_q}) == 4'(MAX_MOVES);

  sum15_check u_c_check (
    .m0_i  (c_slot_q[0]),
    .m1_i  (c_slot_q[1]),
    .m2_i  (c_slot_q[2]),
    .m3_i  (c_slot_q[3]),
    .fill_i(c_cnt_q),
    .win_o (c_win)
  );

  sum15_check u_h_check (
    .m0_i  (h_slot_q[0]),
    .m1_i  (h_slot_q[1]),
    .m2_i  (h_slot_q[2]),
    .m3_i  (h_slot_q[3]),
    .fill_i(h_cnt_q),
    .win_o (h_win)
  );

  always_comb begin
    state_d   = state_q;
    c_slot_d  = c_slot_q;
    h_slot_d  = h_slot_q;
    c_cnt_d   = c_cnt_q;
    h_cnt_d   = h_cnt_q;
    taken_d   = taken_q;
    cwin_d    = cwin_q;
    hwin_d    = hwin_q;
    draw_d    = draw_q;
    illegal_d = 1'b0;

    unique case (state_q)
      INIT: begin
`ifdef GAME_SEQ_HUMAN_FIRST_EN
        state_d = H_WAIT;
`else
        state_d = C_WAIT;
`endif
      end
      C_WAIT: begin
        if (eng.cValid && c_legal) begin
          c_slot_d[c_cnt_q[1:0]] = eng.cMove;
          c_cnt_d                = c_cnt_q + 3'd1;
          taken_d                = taken_q | c_bit;
          state_d                = C_CHECK;
        end
      end
      C_CHECK: begin
        if (c_win) begin
          cwin_d  = 1'b1;
          state_d = DONE;
        end else if (all_played) begin
          draw_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = H_WAIT;
        end
      end
      H_WAIT: begin
        if (press) begin
          if (h_legal) begin
            h_slot_d[h_cnt_q[1:0]] = hMove;
            h_cnt_d                = h_cnt_q + 3'd1;
            taken_d                = taken_q | h_bit;
            state_d                = H_CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      H_CHECK: begin
        if (h_win) begin
          hwin_d  = 1'b1;
          state_d = DONE;
        end else if (all_played) begin
          draw_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = C_WAIT;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_L || !newGame_L) begin
      state_q      <= INIT;
      c_slot_q     <= '{default: '0};
      h_slot_q     <= '{default: '0};
      c_cnt_q      <= '0;
      h_cnt_q      <= '0;
      taken_q      <= '0;
      cwin_q       <= 1'b0;
      hwin_q       <= 1'b0;
      draw_q       <= 1'b0;
      illegal_q    <= 1'b0;
      enter_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      c_slot_q     <= c_slot_d;
      h_slot_q     <= h_slot_d;
      c_cnt_q      <= c_cnt_d;
      h_cnt_q      <= h_cnt_d;
      taken_q      <= taken_d;
      cwin_q       <= cwin_d;
      hwin_q       <= hwin_d;
      draw_q       <= draw_d;
      illegal_q    <= illegal_d;
      enter_prev_q <= enter_L;
    end
  end

  assign eng.cReq = (state_q == C_WAIT);
  assign h0       = h_slot_q[0];
  assign h1       = h_slot_q[1];
  assign h2       = h_slot_q[2];
  assign h3       = h_slot_q[3];
  assign c0       = c_slot_q[0];
  assign c1       = c_slot_q[1];
  assign c2       = c_slot_q[2];
  assign c3       = c_slot_q[3];
  assign taken    = taken_q;
  assign cWin     = cwin_q;
  assign hWin     = hwin_q;
  assign draw     = draw_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a move-list model checked every cycle.
module tb_game_sequencer;

  logic       clock = 1'b0;
  logic       reset_L, newGame_L, enter_L;
  logic [3:0] hMove;
  logic [3:0] h3, h2, h1, h0, c3, c2, c1, c0;
  logic [8:0] taken;
  logic       cWin, hWin, draw, illegal;

  int errors = 0;
  int checks = 0;
  int ill_cnt = 0;

  game_sequencer_if eng ();

  game_sequencer dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .newGame_L(newGame_L),
    .enter_L  (enter_L),
    .hMove    (hMove),
    .eng      (eng.slave),
    .h3(h3), .h2(h2), .h1(h1), .h0(h0),
    .c3(c3), .c2(c2), .c1(c1), .c0(c0),
    .taken    (taken),
    .cWin     (cWin),
    .hWin     (hWin),
    .draw     (draw),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: move lists as queues, turn/phase bookkeeping, brute-force triple search.
  int   cl[$];
  int   hl[$];
  bit   m_taken [1:9];
  bit   m_cwin, m_hwin, m_draw, m_ill, m_prev, m_valid;
  int   m_phase;  // 0 start, 1 awaiting move, 2 judging, 3 over
  bit   m_human;  // whose turn

  function automatic bit has15(input int q[$]);
    for (int i = 0; i < q.size(); i++)
      for (int j = i + 1; j < q.size(); j++)
        for (int k = j + 1; k < q.size(); k++)
          if (q[i] + q[j] + q[k] == 15) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] pack(input int q[$]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < q.size() && i < 4; i++) r[i*4 +: 4] = 4'(q[i]);
    return r;
  endfunction

  function automatic bit legal(input int m);
    if (m < 1 || m > 9) return 1'b0;
    return !m_taken[m];
  endfunction

  function automatic logic [8:0] taken_vec();
    logic [8:0] v;
    for (int i = 1; i <= 9; i++) v[i-1] = m_taken[i];
    return v;
  endfunction

  always @(posedge clock) begin
    if (!reset_L || !newGame_L) begin
      cl.delete(); hl.delete();
      for (int i = 1; i <= 9; i++) m_taken[i] = 1'b0;
      m_cwin = 0; m_hwin = 0; m_draw = 0; m_ill = 0;
      m_prev = 1; m_phase = 0; m_human = 0; m_valid = 1;
    end else if (m_valid) begin
      bit press;
      press = m_prev && !enter_L;
      m_ill = 0;
      case (m_phase)
        0: begin m_phase = 1; m_human = 0; end
        1: begin
          if (!m_human && eng.cValid && legal(int'(eng.cMove))) begin
            cl.push_back(int'(eng.cMove)); m_taken[eng.cMove] = 1; m_phase = 2;
          end else if (m_human && press) begin
            if (legal(int'(hMove))) begin
              hl.push_back(int'(hMove)); m_taken[hMove] = 1; m_phase = 2;
            end else m_ill = 1;
          end
        end
        2: begin
          if (has15(m_human ? hl : cl)) begin
            if (m_human) m_hwin = 1; else m_cwin = 1;
            m_phase = 3;
          end else if (cl.size() + hl.size() == 8) begin
            m_draw = 1; m_phase = 3;
          end else begin
            m_human = !m_human; m_phase = 1;
          end
        end
        default: ;
      endcase
      m_prev = enter_L;
    end
  end

  always @(negedge clock) begin
    if (illegal === 1'b1) ill_cnt++;
    if (m_valid) begin
      chk("cReq",    32'(eng.cReq), 32'(m_phase == 1 && !m_human));
      chk("hlist",   32'({h3, h2, h1, h0}), 32'(pack(hl)));
      chk("clist",   32'({c3, c2, c1, c0}), 32'(pack(cl)));
      chk("taken",   32'(taken), 32'(taken_vec()));
      chk("flags",   32'({cWin, hWin, draw}), 32'({m_cwin, m_hwin, m_draw}));
      chk("illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic cmove(input logic [3:0] m);
    int n = 0;
    while (eng.cReq !== 1'b1 && n < 20) begin tick(1); n++; end
    if (n == 20) chk("cReq_timeout", 32'(eng.cReq), 32'd1);
    eng.cMove  = m;
    eng.cValid = 1'b1;
    tick(1);
    eng.cValid = 1'b0;
    tick(1);
  endtask

  task automatic hmove(input logic [3:0] m);
    hMove   = m;
    enter_L = 1'b0;
    tick(1);
    enter_L = 1'b1;
    tick(1);
  endtask

  task automatic restart(input bit use_reset);
    if (use_reset) reset_L = 1'b0; else newGame_L = 1'b0;
    tick(1);
    chk("cReq_in_restart", 32'(eng.cReq), 32'd0);
    reset_L = 1'b1; newGame_L = 1'b1;
    tick(1);
    chk("cReq_after_release", 32'(eng.cReq), 32'd1);
    chk("taken_after_release", 32'(taken), 32'd0);
    chk("lists_after_release", 32'({h3, h2, h1, h0, c3, c2, c1, c0}), 32'd0);
    chk("flags_after_release", 32'({cWin, hWin, draw}), 32'd0);
  endtask

  initial begin
    int base;
    reset_L = 1'b0; newGame_L = 1'b1; enter_L = 1'b1; hMove = '0;
    eng.cMove = '0; eng.cValid = 1'b0;
    m_valid = 0;
    tick(2);
    chk("reset_cReq", 32'(eng.cReq), 32'd0);
    chk("reset_taken", 32'(taken), 32'd0);
    reset_L = 1'b1;
    tick(1);
    chk("cReq_rise", 32'(eng.cReq), 32'd1);

    // Computer win: 5,4,6
    cmove(5); hmove(1); cmove(4); hmove(9); cmove(6);
    chk("cwin_flag", 32'(cWin), 32'd1);
    chk("cwin_list", 32'({c2, c1, c0}), 32'h645);
    chk("cwin_cReq", 32'(eng.cReq), 32'd0);
    hmove(2);
    chk("done_taken", 32'(taken), 32'h139);
    chk("done_h2", 32'(h2), 32'd0);

    // Human win: 5,4,6
    restart(0);
    cmove(1); hmove(5); cmove(2); hmove(4); cmove(3); hmove(6);
    chk("hwin_flag", 32'(hWin), 32'd1);
    chk("hwin_list", 32'({h2, h1, h0}), 32'h645);
    chk("hwin_cwin", 32'(cWin), 32'd0);

    // Draw with 6 never played
    restart(0);
    cmove(1); hmove(4); cmove(2); hmove(5); cmove(3); hmove(8); cmove(7); hmove(9);
    chk("draw_flag", 32'(draw), 32'd1);
    chk("draw_taken", 32'(taken), 32'(9'b111011111));

    // Illegal human moves: taken, zero, out of range
    restart(0);
    cmove(5);
    base = ill_cnt;
    hmove(5); hmove(0); hmove(10);
    chk("illegal_pulses", 32'(ill_cnt - base), 32'd3);
    chk("illegal_h0", 32'(h0), 32'd0);
    chk("illegal_cReq", 32'(eng.cReq), 32'd0);
    hmove(3);
    chk("after_illegal_h0", 32'(h0), 32'd3);
    chk("after_illegal_cReq", 32'(eng.cReq), 32'd1);

    // Held enter and dropped cValid
    restart(1);
    cmove(5);
    hMove = 4'd6; enter_L = 1'b0;
    tick(10);
    enter_L = 1'b1;
    tick(1);
    chk("held_h0", 32'(h0), 32'd6);
    chk("held_h1", 32'(h1), 32'd0);
    cmove(1);
    eng.cMove = 4'd2; eng.cValid = 1'b1;
    tick(1);
    eng.cValid = 1'b0;
    tick(1);
    chk("dropped_c2", 32'(c2), 32'd0);
    chk("dropped_taken", 32'(taken), 32'h031);

    // Mid-game restarts via each input
    restart(0);
    cmove(5); hmove(6);
    chk("mid_taken", 32'(taken), 32'h030);
    restart(0);
    cmove(5); hmove(6);
    restart(1);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
